maze_collision_points: RTL and testbench



---
 rtl/vga_pkg.sv | 39 +++
 rtl/wall_hit.sv | 30 +++
 rtl/maze_collision_points.sv | 122 ++++++++++++
 tb/tb_maze_collision_points.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared screen geometry, sprite sizes, wall table and gameplay types for the maze game.
package vga_pkg;

    localparam int unsigned SCREEN_WIDTH  = 800;
    localparam int unsigned SCREEN_HEIGHT = 600;
    localparam int unsigned PLAYER_SIZE   = 8;
    localparam int unsigned POINT_SIZE    = 4;
    localparam int unsigned MAX_WALLS     = 4;

    localparam logic [10:0] PS11 = 11'(PLAYER_SIZE);
    localparam logic [10:0] QS11 = 11'(POINT_SIZE);

    localparam logic [9:0] POINT_RST_X = 10'd400;
    localparam logic [9:0] POINT_RST_Y = 10'd300;

    typedef struct packed {
        logic [9:0] x0;
        logic [9:0] y0;
        logic [9:0] x1;
        logic [9:0] y1;
    } wall_t;

    localparam wall_t WALLS [MAX_WALLS] = '{
        '{10'd100, 10'd0,   10'd107, 10'd299},
        '{10'd300, 10'd200, 10'd307, 10'd599},
        '{10'd500, 10'd0,   10'd507, 10'd299},
        '{10'd600, 10'd400, 10'd799, 10'd407}
    };

    typedef enum logic {StIdle, StSeek} state_e;

    // Player square (half-size PS) against point square (half-size QS), subtraction-free.
    function automatic logic squares_overlap(input logic [10:0] px, input logic [10:0] py,
                                             input logic [10:0] qx, input logic [10:0] qy);
        return (px + 11'd1 <= qx + QS11 + PS11) && (qx + 11'd1 <= px + PS11 + QS11) &&
               (py + 11'd1 <= qy + QS11 + PS11) && (qy + 11'd1 <= py + PS11 + QS11);
    endfunction

endpackage

// File: rtl/wall_hit.sv
// Combinational overlap check of a rectangle against the wall table. The rectangle is given
// with every coordinate biased by +Off so no subtraction is ever needed.
module wall_hit
    import vga_pkg::*;
#(
    parameter int unsigned NumWalls = 4,
    parameter int unsigned Off      = 8
) (
    input  logic [10:0] x_lo_i,
    input  logic [10:0] x_hi_i,
    input  logic [10:0] y_lo_i,
    input  logic [10:0] y_hi_i,
    output logic        hit_o
);

    localparam logic [10:0] Off11 = 11'(Off);

    always_comb begin
        hit_o = 1'b0;
        for (int unsigned i = 0; i < NumWalls; i++) begin
            if (({1'b0, WALLS[i].x0} + Off11 <= x_hi_i) &&
                (x_lo_i <= {1'b0, WALLS[i].x1} + Off11) &&
                ({1'b0, WALLS[i].y0} + Off11 <= y_hi_i) &&
                (y_lo_i <= {1'b0, WALLS[i].y1} + Off11)) begin
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/maze_collision_points.sv
// Maze gameplay: per-direction wall/edge collisions, point pickup counting and LFSR re-spawn.
// Wall tests are enabled by defining MAZE_WALLS_EN; otherwise only screen edges apply.
module maze_collision_points
    import vga_pkg::*;
#(
    parameter int unsigned NUM_WALLS = 4,
    parameter logic [19:0] LFSR_SEED = 20'h0ACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic       collision_up,
    output logic       collision_down,
    output logic       collision_left,
    output logic       collision_right,
    output logic [9:0] point_x,
    output logic [9:0] point_y,
    output logic [4:0] points
);

`ifdef MAZE_WALLS_EN
    localparam int unsigned WallCnt = (NUM_WALLS > MAX_WALLS) ? MAX_WALLS : NUM_WALLS;
`else
    // A zero-entry table makes every wall_hit instance a constant miss.
    localparam int unsigned WallCnt = 0 * NUM_WALLS;
`endif

    logic [10:0] px, py, cx, cy;
    logic        hit_up, hit_down, hit_left, hit_right, hit_spawn;
    logic        overlap, cand_ok;

    state_e      state_q, state_d;
    logic [19:0] lfsr_q, lfsr_d;
    logic [4:0]  points_q, points_d;
    logic [9:0]  point_x_q, point_x_d, point_y_q, point_y_d;

    assign px = {1'b0, player_x};
    assign py = {1'b0, player_y};
    assign cx = {1'b0, lfsr_q[9:0]};
    assign cy = {1'b0, lfsr_q[19:10]};

    // Each probe is the 1-px strip the player would enter, biased by +PS.
    wall_hit #(.NumWalls(WallCnt), .Off(PLAYER_SIZE)) u_hit_up (
        .x_lo_i(px + 11'd1), .x_hi_i(px + PS11 + PS11), .y_lo_i(py), .y_hi_i(py),
        .hit_o (hit_up)
    );
    wall_hit #(.NumWalls(WallCnt), .Off(PLAYER_SIZE)) u_hit_down (
        .x_lo_i(px + 11'd1), .x_hi_i(px + PS11 + PS11),
        .y_lo_i(py + PS11 + PS11 + 11'd1), .y_hi_i(py + PS11 + PS11 + 11'd1),
        .hit_o (hit_down)
    );
    wall_hit #(.NumWalls(WallCnt), .Off(PLAYER_SIZE)) u_hit_left (
        .x_lo_i(px), .x_hi_i(px), .y_lo_i(py + 11'd1), .y_hi_i(py + PS11 + PS11),
        .hit_o (hit_left)
    );
    wall_hit #(.NumWalls(WallCnt), .Off(PLAYER_SIZE)) u_hit_right (
        .x_lo_i(px + PS11 + PS11 + 11'd1), .x_hi_i(px + PS11 + PS11 + 11'd1),
        .y_lo_i(py + 11'd1), .y_hi_i(py + PS11 + PS11),
        .hit_o (hit_right)
    );
    wall_hit #(.NumWalls(WallCnt), .Off(POINT_SIZE)) u_hit_spawn (
        .x_lo_i(cx + 11'd1), .x_hi_i(cx + QS11 + QS11),
        .y_lo_i(cy + 11'd1), .y_hi_i(cy + QS11 + QS11),
        .hit_o (hit_spawn)
    );

    assign collision_up    = (py <= PS11) || hit_up;
    assign collision_down  = (py + PS11 >= 11'(SCREEN_HEIGHT - 1)) || hit_down;
    assign collision_left  = (px <= PS11) || hit_left;
    assign collision_right = (px + PS11 >= 11'(SCREEN_WIDTH - 1)) || hit_right;

    assign overlap = squares_overlap(px, py, {1'b0, point_x_q}, {1'b0, point_y_q});
    assign cand_ok = (cx >= QS11) && (cx <= 11'(SCREEN_WIDTH - 1 - POINT_SIZE)) &&
                     (cy >= QS11) && (cy <= 11'(SCREEN_HEIGHT - 1 - POINT_SIZE)) &&
                     !hit_spawn && !squares_overlap(px, py, cx, cy);

    always_comb begin
        state_d   = state_q;
        points_d  = points_q;
        point_x_d = point_x_q;
        point_y_d = point_y_q;
        lfsr_d    = {lfsr_q[18:0], lfsr_q[19] ^ lfsr_q[16]};
        unique case (state_q)
            StIdle: begin
                if (overlap) begin
                    if (points_q != 5'd31) points_d = points_q + 5'd1;
                    state_d = StSeek;
                end
            end
            StSeek: begin
                if (cand_ok) begin
                    point_x_d = lfsr_q[9:0];
                    point_y_d = lfsr_q[19:10];
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            lfsr_q    <= LFSR_SEED;
            points_q  <= 5'd0;
            point_x_q <= POINT_RST_X;
            point_y_q <= POINT_RST_Y;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            points_q  <= points_d;
            point_x_q <= point_x_d;
            point_y_q <= point_y_d;
        end
    end

    assign point_x = point_x_q;
    assign point_y = point_y_q;
    assign points  = points_q;

endmodule

// File: tb/tb_maze_collision_points.sv
// Directed bench for maze_collision_points: collisions, pickup, saturation, mid-search reset.
module tb_maze_collision_points;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] player_x, player_y;
    logic       collision_up, collision_down, collision_left, collision_right;
    logic [9:0] point_x, point_y;
    logic [4:0] points;

    int vectors = 0;
    int miscompares = 0;

`ifdef MAZE_WALLS_EN
    localparam logic W = 1'b1;
`else
    localparam logic W = 1'b0;
`endif

    maze_collision_points #(.NUM_WALLS(4), .LFSR_SEED(20'h0ACE1)) dut (
        .clk            (clk),
        .rst            (rst),
        .player_x       (player_x),
        .player_y       (player_y),
        .collision_up   (collision_up),
        .collision_down (collision_down),
        .collision_left (collision_left),
        .collision_right(collision_right),
        .point_x        (point_x),
        .point_y        (point_y),
        .points         (points)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Independent legality model of a spawned point given the player position.
    function automatic logic legal(input int x, input int y, input int plx, input int ply);
        int wx0[4] = '{100, 300, 500, 600};
        int wy0[4] = '{0, 200, 0, 400};
        int wx1[4] = '{107, 307, 507, 799};
        int wy1[4] = '{299, 599, 299, 407};
        logic ok;
        ok = (x >= 4) && (x <= 795) && (y >= 4) && (y <= 595);
        if (W) begin
            for (int i = 0; i < 4; i++) begin
                if (wx0[i] <= x + 4 && x - 3 <= wx1[i] && wy0[i] <= y + 4 && y - 3 <= wy1[i])
                    ok = 1'b0;
            end
        end
        if (plx + 1 <= x + 12 && x + 1 <= plx + 12 && ply + 1 <= y + 12 && y + 1 <= ply + 12)
            ok = 1'b0;
        return ok;
    endfunction

    task automatic set_player(input int x, input int y);
        @(negedge clk);
        player_x = 10'(x);
        player_y = 10'(y);
        #1;
    endtask

    task automatic check_coll(input string tag, input logic up, input logic dn,
                              input logic lf, input logic rt);
        check({tag, "_up"}, 32'(collision_up), 32'(up));
        check({tag, "_down"}, 32'(collision_down), 32'(dn));
        check({tag, "_left"}, 32'(collision_left), 32'(lf));
        check({tag, "_right"}, 32'(collision_right), 32'(rt));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (dut.state_q !== 1'b0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_seek_done"}, 32'(dut.state_q), 32'd0);
    endtask

    initial begin
        int exp_pts;
        int plx, ply;

        rst = 1'b1;
        player_x = 10'd20;
        player_y = 10'd500;
        repeat (2) @(posedge clk);
        #1;
        check("rst_points", 32'(points), 32'd0);
        check("rst_point_x", 32'(point_x), 32'd400);
        check("rst_point_y", 32'(point_y), 32'd300);
        check("rst_state", 32'(dut.state_q), 32'd0);
        check("rst_lfsr", 32'(dut.lfsr_q), 32'h0ACE1);
        @(negedge clk);
        rst = 1'b0;

        set_player(91, 50);   check_coll("wall_r_hit", 1'b0, 1'b0, 1'b0, W);
        set_player(90, 50);   check_coll("wall_r_miss", 1'b0, 1'b0, 1'b0, 1'b0);
        set_player(8, 8);     check_coll("edge_ul", 1'b1, 1'b0, 1'b1, 1'b0);
        set_player(791, 591); check_coll("edge_dr", 1'b0, 1'b1, 1'b0, 1'b1);
        set_player(103, 307); check_coll("wall_u_hit", W, 1'b0, 1'b0, 1'b0);
        set_player(103, 308); check_coll("wall_u_miss", 1'b0, 1'b0, 1'b0, 1'b0);
        set_player(303, 191); check_coll("wall_d_hit", 1'b0, W, 1'b0, 1'b0);
        set_player(303, 190); check_coll("wall_d_miss", 1'b0, 1'b0, 1'b0, 1'b0);
        set_player(115, 50);  check_coll("wall_l_hit", 1'b0, 1'b0, W, 1'b0);
        set_player(116, 50);  check_coll("wall_l_miss", 1'b0, 1'b0, 1'b0, 1'b0);
        check("no_pickup_yet", 32'(points), 32'd0);

        // First pickup at the reset position.
        set_player(400, 300);
        @(posedge clk);
        #1;
        check("pick1_points", 32'(points), 32'd1);
        check("pick1_state", 32'(dut.state_q), 32'd1);
        wait_idle("pick1");
        check("pick1_moved", 32'(point_x != 10'd400 || point_y != 10'd300), 32'd1);
        check("pick1_legal", 32'(legal(int'(point_x), int'(point_y), 400, 300)), 32'd1);
        check("pick1_once", 32'(points), 32'd1);

        // Pickups 2..32, player left on the old point throughout each search.
        for (int k = 2; k <= 32; k++) begin
            plx = int'(point_x);
            ply = int'(point_y);
            set_player(plx, ply);
            @(posedge clk);
            #1;
            exp_pts = (k > 31) ? 31 : k;
            check($sformatf("pick%0d_points", k), 32'(points), 32'(exp_pts));
            check($sformatf("pick%0d_state", k), 32'(dut.state_q), 32'd1);
            wait_idle($sformatf("pick%0d", k));
            check($sformatf("pick%0d_once", k), 32'(points), 32'(exp_pts));
            check($sformatf("pick%0d_legal", k),
                  32'(legal(int'(point_x), int'(point_y), plx, ply)), 32'd1);
        end

        // Reset asserted the cycle after a pickup, during the search.
        set_player(int'(point_x), int'(point_y));
        @(posedge clk);
        #1;
        check("sat_points", 32'(points), 32'd31);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_points", 32'(points), 32'd0);
        check("midrst_point_x", 32'(point_x), 32'd400);
        check("midrst_point_y", 32'(point_y), 32'd300);
        check("midrst_state", 32'(dut.state_q), 32'd0);
        check("midrst_lfsr", 32'(dut.lfsr_q), 32'h0ACE1);
        @(negedge clk);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
